// File: rtl/pattern_detector_pkg.sv
// pattern_detector_pkg: shared FSM state type and constants (PATTERN_DETECTOR_OVERLAP_EN selects hit successor)
package pattern_detector_pkg;
  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S10  = 2'b10,
    S101 = 2'b11
  } state_t;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int HIST_W = 4;
`ifdef PATTERN_DETECTOR_OVERLAP_EN
  localparam state_t HIT_NEXT = S1;
`else
  localparam state_t HIT_NEXT = S0;
`endif
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high reset
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count up on inc, stick at all-ones instead of wrapping
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pattern_detector.sv
// pattern_detector: serial 1011 detector with match pulse, saturating count and bit history (PATTERN_DETECTOR_OVERLAP_EN enables overlapping matches)
module pattern_detector
  import pattern_detector_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic              valid,
  output logic              match,
  output logic [CNT_W-1:0]  count,
  output logic [HIST_W-1:0] hist
);
  state_t state, state_nx;
  logic hit;
  // state, registered match pulse and history shift on consumed bits
  always_ff @(posedge clk)
    if (rst) begin
      state <= S0;
      match <= 1'b0;
      hist  <= '0;
    end else begin
      state <= state_nx;
      match <= hit;
      if (valid) hist <= {hist[HIST_W-2:0], d};
    end
  // longest matched prefix advances only on qualified bits
  always_comb begin
    state_nx = state;
    hit      = 1'b0;
    if (valid)
      case (state)
        S0:      state_nx = d ? S1 : S0;
        S1:      state_nx = d ? S1 : S10;
        S10:     state_nx = d ? S101 : S0;
        default: begin
          hit      = (d == PATTERN[0]);
          state_nx = hit ? HIT_NEXT : S10;
        end
      endcase
  end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .count (count)
  );
endmodule
